// File: rtl/usb_buf_pkg.sv
// Shared types and sizes for the USB IN-buffer feeder logic.
package usb_buf_pkg;

   localparam int BUF_ADDR_W    = 9;
   localparam int BUF_LEN_W     = 10;
   localparam int BUF_MAX_BYTES = 512;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FILL     = 2'd1,
      COMMIT   = 2'd2,
      WAIT_RDY = 2'd3
   } pkt_state_e;

endpackage : usb_buf_pkg

// File: rtl/usb_idle_timer.sv
// Idle timer: counts enabled cycles and flags the last cycle of the timeout window.
module usb_idle_timer #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic ext_clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int                TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1'b1);

   logic [TMR_W-1:0] tmr_r;

   // Idle counter: clear wins, otherwise count enabled cycles and hold at the terminal value.
   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_r <= {TMR_W{1'b0}};
      end else if (clear) begin
         tmr_r <= {TMR_W{1'b0}};
      end else if (enable && (tmr_r != TMR_LAST)) begin
         tmr_r <= tmr_r + TMR_ONE;
      end else begin
         tmr_r <= tmr_r;
      end
   end

   assign expire = (tmr_r == TMR_LAST);

endmodule : usb_idle_timer

// File: rtl/usb_in_pkt_packer.sv
// usb_in_pkt_packer: packs a valid/ready byte stream into the USB core's IN buffer,
// committing on a full packet, end of transfer or idle timeout, with optional ZLP.
module usb_in_pkt_packer
   import usb_buf_pkg::*;
#(
   parameter int MAX_PKT     = 64,
   parameter int TIMEOUT_CYC = 1024,
   parameter int ZLP_EN      = 1,
   parameter int CNT_W       = 16
) (
   input  logic                  ext_clk,
   input  logic                  reset_n,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [BUF_ADDR_W-1:0] buf_in_addr,
   output logic [7:0]            buf_in_data,
   output logic                  buf_in_wren,
   input  logic                  buf_in_ready,
   output logic                  buf_in_commit,
   output logic [BUF_LEN_W-1:0]  buf_in_commit_len,
   input  logic                  buf_in_commit_ack,
   output logic [CNT_W-1:0]      pkt_cnt,
   output logic                  busy
);

   localparam logic [BUF_LEN_W-1:0] MAX_LEN = BUF_LEN_W'(MAX_PKT);
   localparam logic [BUF_LEN_W-1:0] LEN_ONE = BUF_LEN_W'(1'b1);
   localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1'b1);
   localparam logic                 ZLP_ON  = (ZLP_EN != 0);

   pkt_state_e           state_r;
   pkt_state_e           state_s;
   logic [BUF_LEN_W-1:0] count_r;
   logic [BUF_LEN_W-1:0] count_inc_s;
   logic                 zlp_pend_r;
   logic                 accept_s;
   logic                 full_s;
   logic                 ack_take_s;
   logic                 tmr_clear_s;
   logic                 tmr_en_s;
   logic                 expire_s;
   logic                 zlp_set_s;
   logic                 zlp_clr_s;

   logic                  wren_r;
   logic [BUF_ADDR_W-1:0] addr_r;
   logic [7:0]            data_r;
   logic                  commit_r;
   logic [BUF_LEN_W-1:0]  commit_len_r;
   logic [CNT_W-1:0]      pkt_cnt_r;

   // Stream handshake, packet-full detection, commit acknowledge and idle-timer control.
   always_comb begin
      s_ready     = 1'b0;
      accept_s    = 1'b0;
      tmr_clear_s = 1'b1;
      tmr_en_s    = 1'b0;
      count_inc_s = count_r + LEN_ONE;
      full_s      = (count_inc_s == MAX_LEN);
      ack_take_s  = (state_r == COMMIT) && commit_r && buf_in_commit_ack;
      if (state_r == FILL) begin
         // Acceptance pauses while the core holds the buffer, but the count is kept.
         s_ready     = buf_in_ready;
         accept_s    = s_valid && buf_in_ready;
         tmr_clear_s = accept_s || (count_r == {BUF_LEN_W{1'b0}});
         tmr_en_s    = !accept_s && (count_r != {BUF_LEN_W{1'b0}});
      end else begin
         s_ready     = 1'b0;
         accept_s    = 1'b0;
         tmr_clear_s = 1'b1;
         tmr_en_s    = 1'b0;
      end
   end

   usb_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .ext_clk (ext_clk),
      .reset_n (reset_n),
      .clear   (tmr_clear_s),
      .enable  (tmr_en_s),
      .expire  (expire_s)
   );

   // FSM state register.
   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; a byte accepted on the timeout cycle takes precedence over the timeout.
   always_comb begin
      state_s   = state_r;
      zlp_set_s = 1'b0;
      zlp_clr_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (buf_in_ready) begin
               if (zlp_pend_r) begin
                  state_s   = COMMIT;
                  zlp_clr_s = 1'b1;
               end else begin
                  state_s = FILL;
               end
            end else begin
               state_s = IDLE;
            end
         end
         FILL: begin
            if (accept_s) begin
               if (full_s || s_last) begin
                  state_s   = COMMIT;
                  zlp_set_s = full_s && s_last && ZLP_ON;
               end else begin
                  state_s = FILL;
               end
            end else if (expire_s) begin
               state_s = COMMIT;
            end else begin
               state_s = FILL;
            end
         end
         COMMIT: begin
            if (ack_take_s) begin
               state_s = WAIT_RDY;
            end else begin
               state_s = COMMIT;
            end
         end
         WAIT_RDY: begin
            // One cycle is enough for the core to drop ready; leave regardless.
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Buffer write port, byte count and commit request registers.
   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         wren_r       <= 1'b0;
         addr_r       <= {BUF_ADDR_W{1'b0}};
         data_r       <= 8'h00;
         count_r      <= {BUF_LEN_W{1'b0}};
         commit_r     <= 1'b0;
         commit_len_r <= {BUF_LEN_W{1'b0}};
      end else begin
         wren_r <= accept_s;
         if (accept_s) begin
            addr_r  <= count_r[BUF_ADDR_W-1:0];
            data_r  <= s_data;
            count_r <= count_inc_s;
         end else if (ack_take_s) begin
            count_r <= {BUF_LEN_W{1'b0}};
         end else begin
            count_r <= count_r;
         end
         // Raising commit one cycle after entering COMMIT keeps it behind the last write.
         if ((state_r == COMMIT) && !commit_r) begin
            commit_r     <= 1'b1;
            commit_len_r <= count_r;
         end else if (ack_take_s) begin
            commit_r <= 1'b0;
         end else begin
            commit_r <= commit_r;
         end
      end
   end

   // Pending-ZLP flag and committed-packet counter.
   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         zlp_pend_r <= 1'b0;
         pkt_cnt_r  <= {CNT_W{1'b0}};
      end else begin
         if (zlp_set_s) begin
            zlp_pend_r <= 1'b1;
         end else if (zlp_clr_s) begin
            zlp_pend_r <= 1'b0;
         end else begin
            zlp_pend_r <= zlp_pend_r;
         end
         if (ack_take_s) begin
            pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
         end else begin
            pkt_cnt_r <= pkt_cnt_r;
         end
      end
   end

   assign buf_in_wren       = wren_r;
   assign buf_in_addr       = addr_r;
   assign buf_in_data       = data_r;
   assign buf_in_commit     = commit_r;
   assign buf_in_commit_len = commit_len_r;
   assign pkt_cnt           = pkt_cnt_r;
   assign busy              = (state_r != IDLE);

endmodule : usb_in_pkt_packer

// File: tb/tb_usb_in_pkt_packer.sv
// Scoreboard bench for usb_in_pkt_packer: a transfer-level model predicts buffer writes and commits.
module tb_usb_in_pkt_packer;

   localparam int MAX_PKT     = 64;
   localparam int TIMEOUT_CYC = 16;
   localparam int ZLP_EN      = 1;
   localparam int CNT_W       = 16;

   logic             ext_clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [7:0]       s_data;
   logic             s_valid;
   logic             s_last;
   logic             s_ready;
   logic [8:0]       buf_in_addr;
   logic [7:0]       buf_in_data;
   logic             buf_in_wren;
   logic             buf_in_ready;
   logic             buf_in_commit;
   logic [9:0]       buf_in_commit_len;
   logic             buf_in_commit_ack;
   logic [CNT_W-1:0] pkt_cnt;
   logic             busy;

   usb_in_pkt_packer #(
      .MAX_PKT     (MAX_PKT),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .ZLP_EN      (ZLP_EN),
      .CNT_W       (CNT_W)
   ) dut (
      .ext_clk           (ext_clk),
      .reset_n           (reset_n),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_last            (s_last),
      .s_ready           (s_ready),
      .buf_in_addr       (buf_in_addr),
      .buf_in_data       (buf_in_data),
      .buf_in_wren       (buf_in_wren),
      .buf_in_ready      (buf_in_ready),
      .buf_in_commit     (buf_in_commit),
      .buf_in_commit_len (buf_in_commit_len),
      .buf_in_commit_ack (buf_in_commit_ack),
      .pkt_cnt           (pkt_cnt),
      .busy              (busy)
   );

   typedef struct {
      int addr;
      int data;
   } wr_t;

   typedef struct {
      int len;
      int at;   // expected observation cycle, -1 when not timed
   } cm_t;

   wr_t exp_wr[$];
   cm_t exp_cm[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_count = 0;
   int m_idle = 0;
   int ack_delay = 0;
   int commits_seen = 0;
   int last_len = -1;

   always #5 ext_clk = ~ext_clk;

   always @(posedge ext_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: packetises accepted bytes by the transfer rules.
   initial begin
      wr_t w;
      cm_t c;
      forever begin
         @(negedge ext_clk);
         if (!reset_n) begin
            exp_wr.delete();
            exp_cm.delete();
            m_count = 0;
            m_idle  = 0;
         end else if (s_valid && s_ready) begin
            w.addr = m_count;
            w.data = int'(s_data);
            exp_wr.push_back(w);
            m_count++;
            m_idle = 0;
            if (m_count == MAX_PKT || s_last) begin
               c.len = m_count;
               c.at  = -1;
               exp_cm.push_back(c);
               if (m_count == MAX_PKT && s_last && ZLP_EN != 0) begin
                  c.len = 0;
                  exp_cm.push_back(c);
               end
               m_count = 0;
            end
         end else if (m_count > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
               c.len = m_count;
               c.at  = cyc + 2;
               exp_cm.push_back(c);
               m_count = 0;
               m_idle  = 0;
            end
         end
      end
   end

   // Monitor: compares buffer writes and commits against the scoreboard.
   initial begin
      wr_t w;
      cm_t c;
      logic prev_commit;
      int held_len;
      prev_commit = 1'b0;
      held_len = 0;
      forever begin
         @(negedge ext_clk);
         if (!reset_n) begin
            commits_seen = 0;
            prev_commit  = 1'b0;
         end else begin
            if (buf_in_wren) begin
               if (exp_wr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr=%0d data=%0d, none expected", buf_in_addr, buf_in_data);
               end else begin
                  w = exp_wr.pop_front();
                  chk("write_addr", buf_in_addr, w.addr);
                  chk("write_data", buf_in_data, w.data);
               end
            end
            if (buf_in_commit && !prev_commit) begin
               if (exp_cm.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit: len=%0d, none expected", buf_in_commit_len);
               end else begin
                  c = exp_cm.pop_front();
                  chk("commit_len", buf_in_commit_len, c.len);
                  if (c.at >= 0) chk("timeout_commit_cycle", cyc, c.at);
               end
               chk("pkt_cnt_at_commit", pkt_cnt, commits_seen % (1 << CNT_W));
               held_len = buf_in_commit_len;
               last_len = buf_in_commit_len;
            end
            if (buf_in_commit) begin
               chk("no_write_during_commit", buf_in_wren, 0);
               chk("s_ready_low_during_commit", s_ready, 0);
               chk("busy_during_commit", busy, 1);
               if (prev_commit) chk("commit_len_stable", buf_in_commit_len, held_len);
            end
            if (prev_commit && !buf_in_commit) begin
               commits_seen++;
               chk("pkt_cnt_after_ack", pkt_cnt, commits_seen % (1 << CNT_W));
            end
            if (!buf_in_ready) chk("s_ready_follows_buf_ready", s_ready, 0);
            prev_commit = buf_in_commit;
         end
      end
   end

   // Core-side acknowledge: answers each commit after ack_delay cycles with a one-cycle pulse.
   initial begin
      int ack_wait;
      ack_wait = 0;
      buf_in_commit_ack = 1'b0;
      forever begin
         @(posedge ext_clk);
         #1;
         if (!reset_n) begin
            buf_in_commit_ack = 1'b0;
            ack_wait = 0;
         end else if (buf_in_commit && !buf_in_commit_ack) begin
            if (ack_wait >= ack_delay) begin
               buf_in_commit_ack = 1'b1;
               ack_wait = 0;
            end else begin
               ack_wait++;
            end
         end else begin
            buf_in_commit_ack = 1'b0;
         end
      end
   end

   task automatic gap(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) begin
         @(posedge ext_clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      s_data  = d;
      s_last  = l;
      s_valid = 1'b1;
      while (!done) begin
         @(negedge ext_clk);
         if (s_ready) done = 1'b1;
         @(posedge ext_clk);
         #1;
         guard++;
         if (!done && guard >= 400) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte not accepted after %0d cycles", guard);
            done = 1'b1;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_xfer(input int n, input int maxgap, input bit seq);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = seq ? i[7:0] : 8'($urandom);
         send_byte(d, i == n - 1);
         if (maxgap > 0) gap($urandom_range(maxgap, 0));
      end
   endtask

   task automatic wait_quiet();
      int g;
      g = 0;
      while ((exp_cm.size() != 0 || exp_wr.size() != 0 || m_count != 0 || buf_in_commit) && g < 3000) begin
         @(posedge ext_clk);
         #1;
         g++;
      end
      checks++;
      if (g >= 3000) begin
         errors++;
         $display("FAIL drain_timeout: %0d commits and %0d writes still outstanding", exp_cm.size(), exp_wr.size());
      end
      gap(4);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_wren"}, buf_in_wren, 0);
      chk({tag, "_addr"}, buf_in_addr, 0);
      chk({tag, "_data"}, buf_in_data, 0);
      chk({tag, "_commit"}, buf_in_commit, 0);
      chk({tag, "_commit_len"}, buf_in_commit_len, 0);
      chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Stimulus sequence.
   initial begin
      int n;
      int r;
      s_data       = 8'h00;
      s_valid      = 1'b0;
      s_last       = 1'b0;
      buf_in_ready = 1'b1;
      reset_n      = 1'b0;
      repeat (3) @(posedge ext_clk);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;
      gap(2);

      // Ten sequential bytes ending with s_last.
      send_xfer(10, 0, 1'b1);
      wait_quiet();
      chk("t1_len", last_len, 10);
      chk("t1_pkt_cnt", pkt_cnt, 1);

      // 150 continuous bytes: 64, 64, 22.
      send_xfer(150, 0, 1'b0);
      wait_quiet();
      chk("t2_last_len", last_len, 22);
      chk("t2_pkt_cnt", pkt_cnt, 4);

      // 128 bytes ending on a packet boundary: 64, 64 and a ZLP.
      send_xfer(128, 0, 1'b0);
      wait_quiet();
      chk("t3_zlp_len", last_len, 0);
      chk("t3_pkt_cnt", pkt_cnt, 7);

      // Five bytes then silence: idle timeout commits them.
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
      wait_quiet();
      chk("t4_timeout_len", last_len, 5);
      chk("t4_pkt_cnt", pkt_cnt, 8);

      // A sixth byte arriving on idle cycle 15 restarts the timer.
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
      gap(14);
      send_byte(8'hA5, 1'b0);
      wait_quiet();
      chk("t4b_timeout_len", last_len, 6);
      chk("t4b_pkt_cnt", pkt_cnt, 9);

      // Slow acknowledge: commit must hold with no writes and no acceptance.
      ack_delay = 20;
      send_xfer(12, 1, 1'b0);
      wait_quiet();
      ack_delay = 0;
      chk("t5_len", last_len, 12);
      chk("t5_pkt_cnt", pkt_cnt, 10);

      // Buffer-ready gap of 8 cycles in the middle of a packet.
      for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
      buf_in_ready = 1'b0;
      fork
         send_byte(8'($urandom), 1'b0);
         begin
            repeat (8) begin
               @(posedge ext_clk);
               #1;
            end
            buf_in_ready = 1'b1;
         end
      join
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
      wait_quiet();
      chk("t6_len", last_len, 13);
      chk("t6_pkt_cnt", pkt_cnt, 11);

      // Randomised transfers with gaps, timeouts, ready drops and ack delays.
      for (int t = 0; t < 25; t++) begin
         ack_delay = $urandom_range(3, 0);
         n = ($urandom_range(5, 0) == 0) ? 64 * $urandom_range(2, 1) : $urandom_range(150, 1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(29, 0) == 0) begin
               buf_in_ready = 1'b0;
               gap($urandom_range(6, 1));
               buf_in_ready = 1'b1;
            end
            send_byte(8'($urandom), i == n - 1);
            r = $urandom_range(39, 0);
            if (r == 0) gap(20);
            else gap(r % 3);
         end
      end
      wait_quiet();
      ack_delay = 0;

      // Reset in the middle of a packet discards it.
      for (int i = 0; i < 30; i++) send_byte(8'($urandom), 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      repeat (3) @(posedge ext_clk);
      #1;
      reset_n = 1'b1;
      chk("post_reset_pkt_cnt", pkt_cnt, 0);
      gap(2);
      send_xfer(10, 0, 1'b1);
      wait_quiet();
      chk("t8_len", last_len, 10);
      chk("t8_pkt_cnt", pkt_cnt, 1);

      chk("leftover_writes", exp_wr.size(), 0);
      chk("leftover_commits", exp_cm.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_usb_in_pkt_packer
